dram_access_sched: RTL

- Sequences the 16-bit DRAM test macro between three requesters: the write engine, the read engine and an internal periodic refresh timer.
- Sits between the test_write_read control logic and the macro pins: R_AD, D_IN, WRI_EN, RD_EN, VSAEN, REF_WWL, DRAM16_data.
- Produces all macro strobe timing.
- Returns read data and completion acks to the engines.

---
 rtl/dram_access_sched_if.sv | 27 ++
 rtl/dram_access_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_access_sched_if.sv
`timescale 1ns/1ps
// Engine-side bus of dram_access_sched.
//   master : the write/read engines (drive requests, address, data)
//   slave  : the scheduler (returns acks and read data)
interface dram_access_sched_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_data
    );
endinterface

// File: rtl/dram_access_sched.sv
`timescale 1ns/1ps
// DRAM macro access scheduler: arbitrates write engine, read engine and a
// periodic refresh timer onto the 16-bit DRAM test macro and generates all
// macro strobe timing.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   ref_en               : refresh timer enable
//   eng (slave)          : engine requests/acks/read data
//   DRAM16_data          : macro read data (sampled while VSAEN is high)
//   R_AD, D_IN           : macro row address / write data
//   WRI_EN, RD_EN, VSAEN : write wordline, read enable, sense amp enable
//   REF_WWL              : refresh write-back wordline
//   busy, ref_miss       : not-idle status, sticky missed-refresh flag
module dram_access_sched #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned REF_INTERVAL = 1560,
    parameter int unsigned WR_CYC       = 4,
    parameter int unsigned RD_CYC       = 6,
    parameter int unsigned SAEN_DLY     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ref_en,
    dram_access_sched_if.slave  eng,
    input  logic [DATA_W-1:0]   DRAM16_data,
    output logic [ADDR_W-1:0]   R_AD,
    output logic [DATA_W-1:0]   D_IN,
    output logic                WRI_EN,
    output logic                RD_EN,
    output logic                VSAEN,
    output logic                REF_WWL,
    output logic                busy,
    output logic                ref_miss
);
    localparam int unsigned CNT_MAX = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(REF_INTERVAL);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_REF_RD = 3'd3;
    localparam logic [2:0] ST_REF_WB = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [TMR_W-1:0]  timer_q,   timer_d;
    logic              ref_pend_q, ref_pend_d;
    logic              ref_miss_q, ref_miss_d;
    logic [ADDR_W-1:0] ref_row_q, ref_row_d;
    logic              last_rd_q, last_rd_d;
    logic [ADDR_W-1:0] rad_q,     rad_d;
    logic [DATA_W-1:0] din_q,     din_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [DATA_W-1:0] wb_q,      wb_d;
    logic              wr_ack_q,  wr_ack_d;
    logic              rd_ack_q,  rd_ack_d;
    logic              wri_en_q,  wri_en_d;
    logic              rd_en_q,   rd_en_d;
    logic              vsaen_q,   vsaen_d;
    logic              ref_wwl_q, ref_wwl_d;
    logic              busy_q,    busy_d;
    logic              ref_done;
    logic              ref_tc;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            ref_pend_q <= 1'b0;
            ref_miss_q <= 1'b0;
            ref_row_q  <= '0;
            last_rd_q  <= 1'b1;
            rad_q      <= '0;
            din_q      <= '0;
            rdata_q    <= '0;
            wb_q       <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            wri_en_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            vsaen_q    <= 1'b0;
            ref_wwl_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            ref_pend_q <= ref_pend_d;
            ref_miss_q <= ref_miss_d;
            ref_row_q  <= ref_row_d;
            last_rd_q  <= last_rd_d;
            rad_q      <= rad_d;
            din_q      <= din_d;
            rdata_q    <= rdata_d;
            wb_q       <= wb_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            wri_en_q   <= wri_en_d;
            rd_en_q    <= rd_en_d;
            vsaen_q    <= vsaen_d;
            ref_wwl_q  <= ref_wwl_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, arbitration, refresh timer and strobe decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        last_rd_d  = last_rd_q;
        rad_d      = rad_q;
        din_d      = din_q;
        rdata_d    = rdata_q;
        wb_d       = wb_q;
        ref_row_d  = ref_row_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        ref_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Refresh first; on a read/write tie grant the type not granted last.
                if (ref_pend_q) begin
                    state_d = ST_REF_RD;
                    rad_d   = ref_row_q;
                end else if (eng.wr_req && (!eng.rd_req || last_rd_q)) begin
                    state_d   = ST_WRITE;
                    rad_d     = eng.wr_addr;
                    din_d     = eng.wr_data;
                    last_rd_d = 1'b0;
                end else if (eng.rd_req) begin
                    state_d   = ST_READ;
                    rad_d     = eng.rd_addr;
                    last_rd_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    wr_ack_d = 1'b1;
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_W'(RD_CYC - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    rdata_d  = DRAM16_data;
                    rd_ack_d = 1'b1;
                end
            end
            ST_REF_RD: begin
                // Captured row goes straight onto D_IN for the write-back.
                if (cnt_q == CNT_W'(RD_CYC - 1)) begin
                    state_d = ST_REF_WB;
                    cnt_d   = '0;
                    wb_d    = DRAM16_data;
                    din_d   = DRAM16_data;
                end
            end
            ST_REF_WB: begin
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    ref_row_d = ref_row_q + ADDR_W'(1);
                    ref_done  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Refresh timer; a terminal count while still pending is a miss.
        ref_tc     = ref_en && (timer_q == TMR_W'(REF_INTERVAL - 1));
        timer_d    = (!ref_en || ref_tc) ? '0 : timer_q + TMR_W'(1);
        ref_pend_d = ref_pend_q;
        ref_miss_d = ref_miss_q;
        if (ref_done) begin
            ref_pend_d = 1'b0;
        end
        if (ref_tc) begin
            if (ref_pend_q) begin
                ref_miss_d = 1'b1;
            end else begin
                ref_pend_d = 1'b1;
            end
        end

        // Strobes follow the upcoming state so they rise with state entry.
        wri_en_d  = (state_d == ST_WRITE);
        rd_en_d   = (state_d == ST_READ) || (state_d == ST_REF_RD);
        vsaen_d   = rd_en_d && (cnt_d >= CNT_W'(SAEN_DLY));
        ref_wwl_d = (state_d == ST_REF_WB);
        busy_d    = (state_d != ST_IDLE);
    end

    assign eng.wr_ack  = wr_ack_q;
    assign eng.rd_ack  = rd_ack_q;
    assign eng.rd_data = rdata_q;
    assign R_AD        = rad_q;
    assign D_IN        = din_q;
    assign WRI_EN      = wri_en_q;
    assign RD_EN       = rd_en_q;
    assign VSAEN       = vsaen_q;
    assign REF_WWL     = ref_wwl_q;
    assign busy        = busy_q;
    assign ref_miss    = ref_miss_q;
endmodule
